// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and widths for the MEM pipeline stage
package mem_stage_pkg;

    localparam int WORD_W   = 32;
    localparam int REG_ID_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - request/grant data-memory port between MEM stage and memory
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [WORD_W-1:0] dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [WORD_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register; a disabled cycle inserts a bubble
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [WORD_W-1:0]   data_i,
    input  logic [REG_ID_W-1:0] reg_id_i,
    input  logic                reg_write_i,
    output logic [WORD_W-1:0]   data_o,
    output logic [REG_ID_W-1:0] reg_id_o,
    output logic                reg_write_o
);

    logic [WORD_W-1:0]   data_q, data_d;
    logic [REG_ID_W-1:0] reg_id_q, reg_id_d;
    logic                reg_write_q, reg_write_d;

    // A bubble only kills the write strobe; data and id keep their last values.
    always_comb begin
        data_d      = data_q;
        reg_id_d    = reg_id_q;
        reg_write_d = 1'b0;
        if (en) begin
            data_d      = data_i;
            reg_id_d    = reg_id_i;
            reg_write_d = reg_write_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            reg_id_q    <= '0;
            reg_write_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            reg_id_q    <= reg_id_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign data_o      = data_q;
    assign reg_id_o    = reg_id_q;
    assign reg_write_o = reg_write_q;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: data-memory access FSM, stall generation, branch resolve, MEM/WB
// Optional alignment trap enabled by defining MEM_STAGE_MISALIGN_CHK_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   result_i,
    input  logic [WORD_W-1:0]   read_data2_i,
    input  logic                zero_i,
    input  logic                branch_i,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic                mem_to_reg_i,
    input  logic                reg_write_i,
    input  logic [REG_ID_W-1:0] reg_id_w_i,
    input  logic [WORD_W-1:0]   branch_pc_i,
    mem_stage_if.master         dmem,
    output logic                stall_o,
    output logic                pc_src_o,
    output logic [WORD_W-1:0]   branch_target_o,
    output logic                flush_o,
    output logic [WORD_W-1:0]   wb_data_o,
    output logic [REG_ID_W-1:0] wb_reg_id_o,
    output logic                wb_reg_write_o,
    output logic                misalign_o
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;

    logic              mem_op;
    logic              misalign_hit;
    logic              stall;
    logic              load_done;
    logic [WORD_W-1:0] wb_data_in;
    logic              wb_write_in;

    assign mem_op = mem_read_i | mem_write_i;

`ifdef MEM_STAGE_MISALIGN_CHK_EN
    assign misalign_hit = (state_q == ST_IDLE) && mem_op && (result_i[1:0] != 2'b00);
`else
    assign misalign_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        stall     = 1'b0;
        load_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A write wins when both read and write are flagged.
                if (mem_op && !misalign_hit) begin
                    state_d = ST_REQ;
                    addr_d  = result_i;
                    wdata_d = read_data2_i;
                    we_d    = mem_write_i;
                    stall   = 1'b1;
                end
            end
            ST_REQ: begin
                stall = !(dmem.dmem_gnt && we_q);
                if (dmem.dmem_gnt) begin
                    state_d = we_q ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = !dmem.dmem_rvalid;
                if (dmem.dmem_rvalid) begin
                    state_d   = ST_IDLE;
                    load_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign dmem.dmem_req   = (state_q == ST_REQ);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign stall_o = stall;

    // Load data is forwarded straight from the memory port in its rvalid cycle.
    assign wb_data_in  = (mem_to_reg_i && load_done) ? dmem.dmem_rdata : result_i;
    assign wb_write_in = reg_write_i && (reg_id_w_i != '0) && !misalign_hit;

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .en          (!stall),
        .data_i      (wb_data_in),
        .reg_id_i    (reg_id_w_i),
        .reg_write_i (wb_write_in),
        .data_o      (wb_data_o),
        .reg_id_o    (wb_reg_id_o),
        .reg_write_o (wb_reg_write_o)
    );

`ifdef MEM_STAGE_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign pc_src_o        = branch_i & zero_i;
    assign branch_target_o = branch_pc_i;
    assign flush_o         = pc_src_o;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized instruction-schedule bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result_i, read_data2_i, branch_pc_i;
    logic        zero_i, branch_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
    logic [4:0]  reg_id_w_i;
    logic        stall_o, pc_src_o, flush_o, wb_reg_write_o, misalign_o;
    logic [31:0] branch_target_o, wb_data_o;
    logic [4:0]  wb_reg_id_o;

    mem_stage_if dmem_if ();

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .result_i        (result_i),
        .read_data2_i    (read_data2_i),
        .zero_i          (zero_i),
        .branch_i        (branch_i),
        .mem_read_i      (mem_read_i),
        .mem_write_i     (mem_write_i),
        .mem_to_reg_i    (mem_to_reg_i),
        .reg_write_i     (reg_write_i),
        .reg_id_w_i      (reg_id_w_i),
        .branch_pc_i     (branch_pc_i),
        .dmem            (dmem_if),
        .stall_o         (stall_o),
        .pc_src_o        (pc_src_o),
        .branch_target_o (branch_target_o),
        .flush_o         (flush_o),
        .wb_data_o       (wb_data_o),
        .wb_reg_id_o     (wb_reg_id_o),
        .wb_reg_write_o  (wb_reg_write_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model expectations: combinational for the current cycle, registered as of the last edge.
    bit          chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_pc_src;
    logic [31:0] exp_addr, exp_wdata, exp_tgt;
    logic        exp_wb_we, exp_mis, exp_data_ok;
    logic [4:0]  exp_wb_id;
    logic [31:0] exp_wb_data;

    int          stall_cnt = 0;
    int          req_cnt   = 0;
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (stall_o === 1'b1) stall_cnt++;
        if (dmem_if.dmem_req === 1'b1) begin
            req_cnt++;
            seen_addr  = dmem_if.dmem_addr;
            seen_wdata = dmem_if.dmem_wdata;
            seen_we    = dmem_if.dmem_we;
        end
        if (chk_en) begin
            chk("stall", {31'd0, stall_o}, {31'd0, exp_stall});
            chk("dmem_req", {31'd0, dmem_if.dmem_req}, {31'd0, exp_req});
            if (exp_req) begin
                chk("dmem_addr", dmem_if.dmem_addr, exp_addr);
                chk("dmem_wdata", dmem_if.dmem_wdata, exp_wdata);
                chk("dmem_we", {31'd0, dmem_if.dmem_we}, {31'd0, exp_we});
            end
            chk("pc_src", {31'd0, pc_src_o}, {31'd0, exp_pc_src});
            chk("flush", {31'd0, flush_o}, {31'd0, exp_pc_src});
            chk("br_target", branch_target_o, exp_tgt);
            chk("wb_we", {31'd0, wb_reg_write_o}, {31'd0, exp_wb_we});
            chk("wb_id", {27'd0, wb_reg_id_o}, {27'd0, exp_wb_id});
            if (exp_data_ok) chk("wb_data", wb_data_o, exp_wb_data);
            chk("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
        end
    end

    task automatic set_idle();
        result_i = 0; read_data2_i = 0; branch_pc_i = 0; zero_i = 0; branch_i = 0;
        mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0; reg_write_i = 0; reg_id_w_i = 0;
        dmem_if.dmem_gnt = 0; dmem_if.dmem_rvalid = 0; dmem_if.dmem_rdata = 0;
    endtask

    // One instruction held in EX/MEM until it retires. kind: 0 ALU, 1 store, 2 load.
    // g = wait cycles before grant, r = wait cycles between grant and rvalid.
    task automatic run_instr(input int kind, input logic [4:0] rd, input logic rw,
                             input logic [31:0] res, input logic [31:0] wd,
                             input int g, input int r, input logic [31:0] rdat,
                             input logic br, input logic zr, input logic [31:0] bpc);
        logic mis, acc, done, chkmis;
        int   n;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        chkmis = 1'b1;
`else
        chkmis = 1'b0;
`endif
        mis = chkmis && (kind != 0) && (res[1:0] != 2'b00);
        acc = (kind != 0) && !mis;
        n   = !acc ? 1 : ((kind == 1) ? 2 + g : 3 + g + r);

        result_i     = res;
        read_data2_i = wd;
        mem_write_i  = (kind == 1);
        mem_read_i   = (kind == 2) || ((kind == 1) && ($urandom_range(0, 1) == 1));
        mem_to_reg_i = (kind == 2);
        reg_write_i  = (kind == 1) ? 1'b0 : rw;
        reg_id_w_i   = rd;
        branch_i     = (kind == 0) && br;
        zero_i       = zr;
        branch_pc_i  = bpc;
        exp_pc_src   = (kind == 0) && br && zr;
        exp_tgt      = bpc;

        for (int c = 0; c < n; c++) begin
            done = acc && (kind == 2) && (c == 2 + g + r);
            dmem_if.dmem_gnt = acc && (c == 1 + g);
            if (done)
                dmem_if.dmem_rvalid = 1'b1;
            else if (!(acc && (kind == 2) && (c >= 2 + g)))
                dmem_if.dmem_rvalid = ($urandom_range(0, 3) == 0);
            else
                dmem_if.dmem_rvalid = 1'b0;
            dmem_if.dmem_rdata = done ? rdat : $urandom;
            exp_stall = (c != n - 1);
            exp_req   = acc && (c >= 1) && (c <= 1 + g);
            exp_addr  = res;
            exp_wdata = wd;
            exp_we    = (kind == 1);
            @(posedge clk); #1;
            if (c == n - 1) begin
                exp_wb_we   = (kind != 1) && rw && (rd != 0) && !mis;
                exp_wb_id   = rd;
                exp_wb_data = (kind == 2 && acc) ? rdat : res;
                exp_data_ok = !mis;
                exp_mis     = mis;
            end else begin
                exp_wb_we = 1'b0;
                exp_mis   = 1'b0;
            end
        end
        dmem_if.dmem_gnt    = 1'b0;
        dmem_if.dmem_rvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, r0, kind, g, r;
        logic [31:0] a, d;
        logic [4:0]  rd;

        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_we", {31'd0, wb_reg_write_o}, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_wb_id", {27'd0, wb_reg_id_o}, 32'd0);
        chk("rst_req", {31'd0, dmem_if.dmem_req}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        rst = 1'b0;
        exp_wb_we = 0; exp_wb_id = 0; exp_wb_data = 0; exp_data_ok = 1; exp_mis = 0;
        exp_stall = 0; exp_req = 0; exp_pc_src = 0; exp_tgt = 0;
        exp_addr = 0; exp_wdata = 0; exp_we = 0;
        chk_en = 1'b1;

        // Minimum-latency store.
        s0 = stall_cnt;
        run_instr(1, 5'd0, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("st_stall_cycles", stall_cnt - s0, 32'd1);
        chk("st_addr", seen_addr, 32'h100);
        chk("st_wdata", seen_wdata, 32'hDEADBEEF);
        chk("st_we", {31'd0, seen_we}, 32'd1);
        chk("st_wb_we", {31'd0, wb_reg_write_o}, 32'd0);

        // Load with rvalid three cycles after an immediate grant.
        s0 = stall_cnt;
        run_instr(2, 5'd5, 1'b1, 32'h40, 32'h0, 0, 2, 32'h12345678, 1'b0, 1'b0, 32'h0);
        chk("ld_stall_cycles", stall_cnt - s0, 32'd4);
        chk("ld_wb_data", wb_data_o, 32'h12345678);
        chk("ld_wb_id", {27'd0, wb_reg_id_o}, 32'd5);
        chk("ld_wb_we", {31'd0, wb_reg_write_o}, 32'd1);

        // ALU ops: x0 never written, x3 written without stalling.
        s0 = stall_cnt;
        run_instr(0, 5'd0, 1'b1, 32'd7, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("alu_x0_we", {31'd0, wb_reg_write_o}, 32'd0);
        run_instr(0, 5'd3, 1'b1, 32'd7, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("alu_x3_data", wb_data_o, 32'd7);
        chk("alu_x3_we", {31'd0, wb_reg_write_o}, 32'd1);
        chk("alu_stall_cycles", stall_cnt - s0, 32'd0);

        // Branch resolution, taken then not taken.
        run_instr(0, 5'd0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1, 1'b1, 32'h80);
        chk("br_taken_pc_src", {31'd0, pc_src_o}, 32'd1);
        chk("br_taken_flush", {31'd0, flush_o}, 32'd1);
        chk("br_taken_target", branch_target_o, 32'h80);
        run_instr(0, 5'd0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1, 1'b0, 32'h80);
        chk("br_nt_pc_src", {31'd0, pc_src_o}, 32'd0);
        chk("br_nt_flush", {31'd0, flush_o}, 32'd0);

        // Misaligned load.
        r0 = req_cnt;
        run_instr(2, 5'd9, 1'b1, 32'h102, 32'h0, 0, 0, 32'h55AA55AA, 1'b0, 1'b0, 32'h0);
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        chk("mis_req_cycles", req_cnt - r0, 32'd0);
        chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
        chk("mis_wb_we", {31'd0, wb_reg_write_o}, 32'd0);
        run_instr(0, 5'd0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
`else
        chk("mis_req_cycles", req_cnt - r0, 32'd1);
        chk("mis_addr_unchanged", seen_addr, 32'h102);
        chk("mis_tied_low", {31'd0, misalign_o}, 32'd0);
`endif

        // Reset while waiting for read data; the late rvalid must be ignored.
        chk_en = 1'b0;
        set_idle();
        result_i = 32'h200; mem_read_i = 1; mem_to_reg_i = 1; reg_write_i = 1; reg_id_w_i = 5'd7;
        @(posedge clk); #1;
        dmem_if.dmem_gnt = 1;
        @(posedge clk); #1;
        dmem_if.dmem_gnt = 0;
        chk("rstw_in_wait_stall", {31'd0, stall_o}, 32'd1);
        rst = 1; mem_read_i = 0; reg_write_i = 0; reg_id_w_i = 0; result_i = 0;
        @(posedge clk); #1;
        chk("rstw_wb_data", wb_data_o, 32'd0);
        chk("rstw_wb_id", {27'd0, wb_reg_id_o}, 32'd0);
        rst = 0;
        dmem_if.dmem_rvalid = 1; dmem_if.dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("rstw_stall", {31'd0, stall_o}, 32'd0);
        chk("rstw_req", {31'd0, dmem_if.dmem_req}, 32'd0);
        @(posedge clk); #1;
        dmem_if.dmem_rvalid = 0;
        chk("rstw_no_capture", wb_data_o, 32'd0);
        chk("rstw_wb_we", {31'd0, wb_reg_write_o}, 32'd0);
        set_idle();
        exp_wb_we = 0; exp_wb_id = 0; exp_wb_data = 0; exp_data_ok = 1; exp_mis = 0;
        exp_stall = 0; exp_req = 0; exp_pc_src = 0; exp_tgt = 0;
        chk_en = 1'b1;

        // Random instruction mix with random memory latencies.
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            a    = $urandom;
            d    = $urandom;
            rd   = 5'($urandom_range(0, 31));
            g    = $urandom_range(0, 3);
            r    = $urandom_range(0, 3);
            if (kind != 0 && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            run_instr(kind, rd, ($urandom_range(0, 3) != 0), a, d, g, r, $urandom,
                      ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
